// File: rtl/pipeline_hazard_ctrl_pkg.sv
// arm_pipe_pkg: shared hazard-controller types and constants for the 4-register ARM pipeline.
package arm_pipe_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FAULT    = 2'd2
    } hazard_state_e;

    localparam int          REG_ADDR_W_DEF = 4;
    localparam logic [3:0]  PC_REG         = 4'd15;

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// load_use_detect: flags an ID instruction reading the destination of a load still in EX.
module load_use_detect
    import arm_pipe_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
    input  logic [REG_ADDR_W-1:0] id_rn,
    input  logic [REG_ADDR_W-1:0] id_rm,
    input  logic                  id_uses_rn,
    input  logic                  id_uses_rm,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    output logic                  load_use
);

    logic w_rn_hit;
    logic w_rm_hit;

    assign w_rn_hit = id_uses_rn & (id_rn == ex_rd);
    assign w_rm_hit = id_uses_rm & (id_rm == ex_rd);
    // A load into the PC is a branch, handled by the flush path rather than a stall
    assign load_use = ex_mem_read & (ex_rd != REG_ADDR_W'(PC_REG)) & (w_rn_hit | w_rm_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer driving PC and pipeline-register controls.
// Optional saturating stall/flush perf counters when PERF_COUNTERS_EN is defined.
module pipeline_hazard_ctrl
    import arm_pipe_pkg::*;
#(
    parameter int REG_ADDR_W  = REG_ADDR_W_DEF,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] id_rn,
    input  logic [REG_ADDR_W-1:0] id_rm,
    input  logic                  id_uses_rn,
    input  logic                  id_uses_rm,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    input  logic                  branch_taken,
    input  logic                  mem_access,
    input  logic                  mem_ready,
    output logic                  pc_enable,
    output logic                  if_id_enable,
    output logic                  if_id_flush,
    output logic                  id_ex_bubble,
    output logic                  ex_mem_enable,
    output logic                  mem_wb_bubble,
    output logic                  mem_fault,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    // r_wcnt counts freeze cycles already spent, so the last wait cycle is MEM_TIMEOUT-1
    localparam logic [7:0] LAST_WAIT = 8'(MEM_TIMEOUT - 1);

    hazard_state_e r_state;
    logic [7:0]    r_wcnt;
    logic          w_load_use;
    logic          w_freeze;
    logic          w_fault;
    logic          w_branch;
    logic          w_stall;

    load_use_detect #(.REG_ADDR_W(REG_ADDR_W)) u_load_use_detect (
        .id_rn       (id_rn),
        .id_rm       (id_rm),
        .id_uses_rn  (id_uses_rn),
        .id_uses_rm  (id_uses_rm),
        .ex_rd       (ex_rd),
        .ex_mem_read (ex_mem_read),
        .load_use    (w_load_use)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= RUN;
            r_wcnt  <= '0;
        end else begin
            unique case (r_state)
                RUN: if (mem_access && !mem_ready) begin
                    r_state <= MEM_WAIT;
                    r_wcnt  <= 8'd1;
                end
                MEM_WAIT: if (mem_ready) begin
                    r_state <= RUN;
                    r_wcnt  <= '0;
                end else if (r_wcnt >= LAST_WAIT) begin
                    r_state <= FAULT;
                    r_wcnt  <= '0;
                end else begin
                    r_wcnt  <= r_wcnt + 8'd1;
                end
                FAULT: r_state <= RUN;
                default: begin
                    r_state <= RUN;
                    r_wcnt  <= '0;
                end
            endcase
        end
    end

    // Priority: freeze > branch flush > load-use; the release cycle of a wait decodes as RUN
    always_comb begin
        w_freeze = !reset && !mem_ready &&
                   ((r_state == MEM_WAIT) || (r_state == RUN && mem_access));
        w_fault  = !reset && (r_state == FAULT);
        w_branch = !reset && !w_fault && !w_freeze && branch_taken;
        w_stall  = !reset && !w_fault && !w_freeze && !branch_taken && w_load_use;
        pc_enable     = !(reset || w_freeze || w_stall);
        if_id_enable  = !(reset || w_freeze || w_stall);
        if_id_flush   = reset || w_fault || w_branch;
        id_ex_bubble  = reset || w_fault || w_branch || w_stall;
        ex_mem_enable = !(reset || w_freeze);
        mem_wb_bubble = reset || w_fault || w_freeze;
        mem_fault     = w_fault;
    end

`ifdef PERF_COUNTERS_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (!pc_enable && !(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (if_id_flush && !(&r_flush_cnt)) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed vectors for the hazard controller, checked against hand-computed output words.
module tb_pipeline_hazard_ctrl;

    // Output word order: {pc_en, if_id_en, if_id_flush, id_ex_bubble, ex_mem_en, mem_wb_bubble, mem_fault}
    localparam logic [6:0] O_RST = 7'b0011010;
    localparam logic [6:0] O_RUN = 7'b1100100;
    localparam logic [6:0] O_LU  = 7'b0001100;
    localparam logic [6:0] O_BR  = 7'b1111100;
    localparam logic [6:0] O_FRZ = 7'b0000010;
    localparam logic [6:0] O_FLT = 7'b1111111;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  id_rn, id_rm, ex_rd;
    logic        id_uses_rn, id_uses_rm, ex_mem_read, branch_taken, mem_access, mem_ready;
    logic        pc_enable, if_id_enable, if_id_flush, id_ex_bubble, ex_mem_enable, mem_wb_bubble, mem_fault;
    logic [15:0] stall_cnt, flush_cnt;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.REG_ADDR_W(4), .MEM_TIMEOUT(16), .CNT_W(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .id_rn         (id_rn),
        .id_rm         (id_rm),
        .id_uses_rn    (id_uses_rn),
        .id_uses_rm    (id_uses_rm),
        .ex_rd         (ex_rd),
        .ex_mem_read   (ex_mem_read),
        .branch_taken  (branch_taken),
        .mem_access    (mem_access),
        .mem_ready     (mem_ready),
        .pc_enable     (pc_enable),
        .if_id_enable  (if_id_enable),
        .if_id_flush   (if_id_flush),
        .id_ex_bubble  (id_ex_bubble),
        .ex_mem_enable (ex_mem_enable),
        .mem_wb_bubble (mem_wb_bubble),
        .mem_fault     (mem_fault),
        .stall_cnt     (stall_cnt),
        .flush_cnt     (flush_cnt)
    );

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] outs();
        return {9'd0, pc_enable, if_id_enable, if_id_flush, id_ex_bubble, ex_mem_enable, mem_wb_bubble, mem_fault};
    endfunction

    task automatic idle();
        id_rn = 4'd0; id_rm = 4'd0; ex_rd = 4'd0;
        id_uses_rn = 1'b0; id_uses_rm = 1'b0; ex_mem_read = 1'b0;
        branch_taken = 1'b0; mem_access = 1'b0; mem_ready = 1'b0;
    endtask

    // Advance to just after the next edge; caller then drives this cycle's inputs
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic look(input string tag, input logic [6:0] exp);
        #1;
        chk(tag, outs(), {9'd0, exp});
    endtask

    initial begin
        idle();
        reset = 1'b1;
        look("reset_outputs", O_RST);
        tick(); look("reset_outputs_2", O_RST);
        tick(); reset = 1'b0; look("run_idle", O_RUN);

        tick(); ex_mem_read = 1'b1; ex_rd = 4'd3; id_rn = 4'd3; id_uses_rn = 1'b1;
        look("lu_rn", O_LU);
        tick(); idle(); look("lu_release", O_RUN);
        tick(); ex_mem_read = 1'b1; ex_rd = 4'd3; id_rm = 4'd3; id_uses_rm = 1'b1;
        look("lu_rm", O_LU);
        tick(); idle(); ex_mem_read = 1'b1; ex_rd = 4'd15; id_rn = 4'd15; id_uses_rn = 1'b1;
        look("lu_pc_dest", O_RUN);
        tick(); ex_rd = 4'd3; id_rn = 4'd3; id_uses_rn = 1'b0;
        look("lu_rn_unused", O_RUN);
        tick(); ex_mem_read = 1'b0; id_uses_rn = 1'b1;
        look("lu_not_load", O_RUN);

        tick(); ex_mem_read = 1'b1; branch_taken = 1'b1;
        look("branch_over_lu", O_BR);

        tick(); idle(); mem_access = 1'b1;
        look("wait_c1", O_FRZ);
        tick(); look("wait_c2", O_FRZ);
        tick(); branch_taken = 1'b1; look("wait_c3_branch_held", O_FRZ);
        tick(); mem_ready = 1'b1; look("wait_release_branch", O_BR);
        tick(); idle(); look("after_release", O_RUN);

        tick(); mem_access = 1'b1; mem_ready = 1'b1;
        look("zero_stall", O_RUN);
        tick(); idle(); look("zero_stall_next", O_RUN);

        tick(); reset = 1'b1; look("reset_again", O_RST);
        tick(); reset = 1'b0; mem_access = 1'b1;
        for (int i = 0; i < 16; i++) begin
            look($sformatf("timeout_frz_%0d", i), O_FRZ);
            tick();
        end
        mem_access = 1'b0;
        look("timeout_fault", O_FLT);
        tick(); look("timeout_back_run", O_RUN);
`ifdef PERF_COUNTERS_EN
        chk("stall_cnt", stall_cnt, 16'd16);
        chk("flush_cnt", flush_cnt, 16'd1);
`else
        chk("stall_cnt_tied", stall_cnt, 16'd0);
        chk("flush_cnt_tied", flush_cnt, 16'd0);
`endif

        tick(); mem_access = 1'b1; look("rst_wait_c1", O_FRZ);
        tick(); look("rst_wait_c2", O_FRZ);
        tick(); reset = 1'b1; look("rst_mid_wait", O_RST);
        tick(); reset = 1'b0; mem_access = 1'b0; look("rst_mid_wait_run", O_RUN);
        chk("rst_mid_wait_wcnt", 16'(dut.r_wcnt), 16'd0);
        for (int i = 0; i < 20; i++) begin
            tick();
            #1;
            chk($sformatf("no_fault_%0d", i), {15'd0, mem_fault}, 16'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
